// File: rtl/drt_device_finder.sv
// Wishbone read master that walks the device ROM table and reports the first
// device whose ID matches a masked request, with its index, offset and size.
module drt_device_finder #(
  parameter logic [31:0] DRT_BASE       = 32'h0000_0000,
  parameter int unsigned HDR_WORDS      = 8,
  parameter int unsigned DEV_WORDS      = 8,
  parameter int unsigned MAX_DEVICES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_match_id,
  input  logic [31:0] i_match_mask,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_found,
  output logic        o_err,
  output logic [31:0] o_num_devices,
  output logic [7:0]  o_dev_index,
  output logic [31:0] o_dev_mem_off,
  output logic [31:0] o_dev_size,
  output logic        o_wbm_cyc,
  output logic        o_wbm_stb,
  output logic        o_wbm_we,
  output logic [3:0]  o_wbm_sel,
  output logic [31:0] o_wbm_adr,
  output logic [31:0] o_wbm_dat,
  input  logic [31:0] i_wbm_dat,
  input  logic        i_wbm_ack
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_OFF  = 3'd3;
  localparam logic [2:0] S_SZ   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [31:0] MAX_DEV    = 32'(MAX_DEVICES);
  localparam logic [31:0] HDR_OFF    = 32'(HDR_WORDS);
  localparam logic [31:0] DEV_STRIDE = 32'(DEV_WORDS);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  pend_q, pend_d;
  logic        rel_q, rel_d;
  logic [7:0]  idx_q, idx_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] id_q, id_d;
  logic [31:0] mask_q, mask_d;
  logic [31:0] num_q, num_d;
  logic [31:0] mem_off_q, mem_off_d;
  logic [31:0] size_q, size_d;
  logic [7:0]  dev_index_q, dev_index_d;
  logic        found_q, found_d;
  logic        err_q, err_d;

  logic        is_read;
  logic        stb;
  logic        hit;
  logic        last_dev;
  logic [31:0] hdr_n;
  logic [31:0] entry;
  logic [31:0] addr;

  assign is_read  = (state_q == S_HDR) || (state_q == S_ID) ||
                    (state_q == S_OFF) || (state_q == S_SZ);
  assign stb      = is_read && !rel_q;
  assign hit      = ((i_wbm_dat ^ id_q) & mask_q) == 32'd0;
  assign last_dev = ({24'd0, idx_q} == (num_q - 32'd1));
  assign hdr_n    = (i_wbm_dat > MAX_DEV) ? MAX_DEV : i_wbm_dat;
  assign entry    = DRT_BASE + HDR_OFF + ({24'd0, idx_q} * DEV_STRIDE);

  always_comb begin
    addr = 32'd0;
    case (state_q)
      S_HDR:   addr = DRT_BASE + 32'd1;
      S_ID:    addr = entry;
      S_OFF:   addr = entry + 32'd2;
      S_SZ:    addr = entry + 32'd3;
      default: addr = 32'd0;
    endcase
  end

  // Each read has a strobe phase (rel_q=0) and an ack-release phase (rel_q=1);
  // the decision taken at ack time is parked in pend_q until ack falls.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rel_d       = rel_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    id_d        = id_q;
    mask_d      = mask_q;
    num_d       = num_q;
    mem_off_d   = mem_off_q;
    size_d      = size_q;
    dev_index_d = dev_index_q;
    found_d     = found_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d     = S_HDR;
          rel_d       = 1'b0;
          tmo_d       = 16'd0;
          idx_d       = 8'd0;
          num_d       = 32'd0;
          mem_off_d   = 32'd0;
          size_d      = 32'd0;
          dev_index_d = 8'd0;
          found_d     = 1'b0;
          err_d       = 1'b0;
          id_d        = i_match_id;
          mask_d      = i_match_mask;
        end
      end
      S_HDR, S_ID, S_OFF, S_SZ: begin
        tmo_d = tmo_q + 16'd1;
        if (!rel_q) begin
          if (i_wbm_ack) begin
            rel_d = 1'b1;
            tmo_d = 16'd0;
            case (state_q)
              S_HDR: begin
                num_d  = hdr_n;
                pend_d = (hdr_n == 32'd0) ? S_DONE : S_ID;
              end
              S_ID: begin
                if (hit) begin
                  pend_d = S_OFF;
                end else if (last_dev) begin
                  pend_d = S_DONE;
                end else begin
                  idx_d  = idx_q + 8'd1;
                  pend_d = S_ID;
                end
              end
              S_OFF: begin
                mem_off_d = i_wbm_dat;
                pend_d    = S_SZ;
              end
              default: begin
                size_d      = i_wbm_dat;
                found_d     = 1'b1;
                dev_index_d = idx_q;
                pend_d      = S_DONE;
              end
            endcase
          end else if (tmo_q == TO_LAST) begin
            err_d   = 1'b1;
            found_d = 1'b0;
            state_d = S_DONE;
          end
        end else begin
          if (!i_wbm_ack) begin
            state_d = pend_q;
            rel_d   = 1'b0;
            tmo_d   = 16'd0;
          end else if (tmo_q == TO_LAST) begin
            err_d   = 1'b1;
            found_d = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= S_IDLE;
      rel_q       <= 1'b0;
      idx_q       <= 8'd0;
      tmo_q       <= 16'd0;
      id_q        <= 32'd0;
      mask_q      <= 32'd0;
      num_q       <= 32'd0;
      mem_off_q   <= 32'd0;
      size_q      <= 32'd0;
      dev_index_q <= 8'd0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rel_q       <= rel_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      id_q        <= id_d;
      mask_q      <= mask_d;
      num_q       <= num_d;
      mem_off_q   <= mem_off_d;
      size_q      <= size_d;
      dev_index_q <= dev_index_d;
      found_q     <= found_d;
      err_q       <= err_d;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_done        = (state_q == S_DONE);
  assign o_found       = found_q;
  assign o_err         = err_q;
  assign o_num_devices = num_q;
  assign o_dev_index   = dev_index_q;
  assign o_dev_mem_off = mem_off_q;
  assign o_dev_size    = size_q;
  assign o_wbm_cyc     = stb;
  assign o_wbm_stb     = stb;
  assign o_wbm_we      = 1'b0;
  assign o_wbm_sel     = 4'hF;
  assign o_wbm_adr     = stb ? addr : 32'd0;
  assign o_wbm_dat     = 32'd0;

endmodule

// File: tb/tb_drt_device_finder.sv
// Scoreboarded bench for drt_device_finder: a memory-backed Wishbone slave,
// a read-sequence reference model, and a monitor that checks every o_done.
module tb_drt_device_finder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_match_id = 32'd0;
  logic [31:0] i_match_mask = 32'd0;
  logic        o_busy, o_done, o_found, o_err;
  logic [31:0] o_num_devices, o_dev_mem_off, o_dev_size;
  logic [7:0]  o_dev_index;
  logic        o_wbm_cyc, o_wbm_stb, o_wbm_we;
  logic [3:0]  o_wbm_sel;
  logic [31:0] o_wbm_adr, o_wbm_dat;
  logic [31:0] wbDat = 32'd0;
  logic        wbAck = 1'b0;

  logic [31:0] mem [0:255];
  int          readCount = 0;
  int          waitCnt = 0;
  int          maxWait = 0;
  logic        noAckEn = 1'b0;
  logic [31:0] noAckAddr = 32'd0;

  int testsRun = 0;
  int failCount = 0;

  typedef struct {
    logic        found;
    logic        err;
    logic [31:0] num;
    logic [7:0]  idx;
    logic [31:0] memOff;
    logic [31:0] size;
    int          reads;
  } exp_t;

  exp_t expQ[$];

  drt_device_finder dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_match_id(i_match_id), .i_match_mask(i_match_mask),
    .o_busy(o_busy), .o_done(o_done), .o_found(o_found), .o_err(o_err),
    .o_num_devices(o_num_devices), .o_dev_index(o_dev_index),
    .o_dev_mem_off(o_dev_mem_off), .o_dev_size(o_dev_size),
    .o_wbm_cyc(o_wbm_cyc), .o_wbm_stb(o_wbm_stb), .o_wbm_we(o_wbm_we),
    .o_wbm_sel(o_wbm_sel), .o_wbm_adr(o_wbm_adr), .o_wbm_dat(o_wbm_dat),
    .i_wbm_dat(wbDat), .i_wbm_ack(wbAck)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem[a[7:0]];
  endfunction

  function automatic logic blocked(input logic [31:0] a);
    return noAckEn && (a == noAckAddr);
  endfunction

  // Slave with random ack latency; ack is held until the master drops stb.
  always @(posedge clk) begin
    if (rst) begin
      wbAck   <= 1'b0;
      waitCnt <= 0;
    end else if (o_wbm_cyc && o_wbm_stb && !wbAck) begin
      if (!blocked(o_wbm_adr)) begin
        if (waitCnt == 0) begin
          wbAck     <= 1'b1;
          wbDat     <= rd(o_wbm_adr);
          readCount <= readCount + 1;
        end else begin
          waitCnt <= waitCnt - 1;
        end
      end
    end else if (!o_wbm_stb) begin
      wbAck   <= 1'b0;
      waitCnt <= $urandom_range(0, maxWait);
    end
  end

  // Reference: the sequence of table reads a search performs, stopping at the
  // first read the slave refuses to acknowledge.
  function automatic exp_t model(input logic [31:0] id, input logic [31:0] mask);
    exp_t e;
    logic [31:0] n;
    logic [31:0] ent;
    e.found = 1'b0; e.err = 1'b0; e.num = 32'd0; e.idx = 8'd0;
    e.memOff = 32'd0; e.size = 32'd0; e.reads = 0;
    if (blocked(32'd1)) begin e.err = 1'b1; return e; end
    e.reads++;
    n = (rd(32'd1) > 32'd16) ? 32'd16 : rd(32'd1);
    e.num = n;
    for (int i = 0; i < int'(n); i++) begin
      ent = 32'(8 + i * 8);
      if (blocked(ent)) begin e.err = 1'b1; return e; end
      e.reads++;
      if (((rd(ent) ^ id) & mask) == 32'd0) begin
        if (blocked(ent + 32'd2)) begin e.err = 1'b1; return e; end
        e.reads++;
        e.memOff = rd(ent + 32'd2);
        if (blocked(ent + 32'd3)) begin e.err = 1'b1; return e; end
        e.reads++;
        e.size  = rd(ent + 32'd3);
        e.found = 1'b1;
        e.idx   = 8'(i);
        return e;
      end
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("resetCtrl", 64'({o_busy, o_done, o_found, o_err, o_wbm_cyc, o_wbm_stb, o_wbm_we, o_dev_index}), 64'd0);
    checkOutput("resetNum", 64'(o_num_devices), 64'd0);
    checkOutput("resetResult", {o_dev_mem_off, o_dev_size}, 64'd0);
    checkOutput("resetBus", {o_wbm_adr, o_wbm_dat}, 64'd0);
  endtask

  task automatic monitorLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && o_done) begin
        if (expQ.size() == 0) begin
          checkOutput("doneWithExpectation", 64'(expQ.size()), 64'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("found", 64'(o_found), 64'(e.found));
          checkOutput("err", 64'(o_err), 64'(e.err));
          checkOutput("numDevices", 64'(o_num_devices), 64'(e.num));
          checkOutput("devIndex", 64'(o_dev_index), 64'(e.idx));
          checkOutput("memOff", 64'(o_dev_mem_off), 64'(e.memOff));
          checkOutput("size", 64'(o_dev_size), 64'(e.size));
          checkOutput("readCount", 64'(readCount), 64'(e.reads));
          checkOutput("busIdleAtDone", 64'({o_wbm_cyc, o_wbm_stb}), 64'd0);
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] id, input logic [31:0] mask, output int cycles);
    exp_t e;
    cycles = 0;
    @(negedge clk);
    e = model(id, mask);
    e.reads = e.reads + readCount;
    expQ.push_back(e);
    i_match_id   = id;
    i_match_mask = mask;
    i_start      = 1'b1;
    @(negedge clk); cycles++;
    i_start      = 1'b0;
    i_match_id   = $urandom;
    i_match_mask = $urandom;
    checkOutput("busyAfterStart", 64'(o_busy), 64'd1);
    @(negedge clk); cycles++;
    i_start = 1'b1;
    @(negedge clk); cycles++;
    i_start = 1'b0;
    while (!o_done && cycles < 4000) begin
      @(negedge clk); cycles++;
    end
    checkOutput("doneWithinBudget", 64'(o_done), 64'd1);
    if (o_done) begin
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      checkOutput("startInDoneIgnored", 64'(o_busy), 64'd0);
    end else begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      expQ.delete();
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic setDev(input int i, input logic [31:0] id, input logic [31:0] off, input logic [31:0] sz);
    mem[8 + i * 8]     = id;
    mem[8 + i * 8 + 1] = 32'h1000_0000 | 32'(i);
    mem[8 + i * 8 + 2] = off;
    mem[8 + i * 8 + 3] = sz;
  endtask

  task automatic buildThreeDevices();
    clearMem();
    mem[1] = 32'd3;
    setDev(0, 32'h10, 32'h0000_1000, 32'h100);
    setDev(1, 32'h20, 32'h0000_2000, 32'h200);
    setDev(2, 32'h30, 32'h0000_3000, 32'h300);
  endtask

  initial begin
    int cyc;
    int k;
    int n;
    logic [31:0] id;
    logic [31:0] mask;
    clearMem();
    fork
      monitorLoop();
    join_none
    #12;
    checkResetOutputs();
    @(negedge clk);
    rst = 1'b0;

    maxWait = 2;
    buildThreeDevices();
    applyStimulus(32'h20, 32'hFFFF_FFFF, cyc);
    applyStimulus(32'h99, 32'hFFFF_FFFF, cyc);
    applyStimulus(32'h31, 32'hFFFF_FFF0, cyc);

    clearMem();
    mem[1] = 32'd0;
    applyStimulus(32'h0, 32'h0, cyc);

    clearMem();
    mem[1] = 32'd40;
    for (int i = 0; i < 24; i++) setDev(i, 32'h100 + 32'(i), 32'h5000 + 32'(i), 32'h60 + 32'(i));
    setDev(20, 32'hABC, 32'h7777, 32'h8888);
    applyStimulus(32'hABC, 32'hFFFF_FFFF, cyc);
    applyStimulus(32'h10F, 32'hFFFF_FFFF, cyc);

    maxWait = 0;
    buildThreeDevices();
    noAckEn   = 1'b1;
    noAckAddr = 32'd8;
    repeat (3) @(negedge clk);
    applyStimulus(32'h20, 32'hFFFF_FFFF, cyc);
    checkOutput("timeoutLatency", 64'(cyc), 64'd260);
    noAckEn = 1'b0;

    maxWait = 2;
    buildThreeDevices();
    @(negedge clk);
    i_match_id   = 32'h20;
    i_match_mask = 32'hFFFF_FFFF;
    i_start      = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    k = 0;
    while (!(o_wbm_stb && o_wbm_adr == 32'd18) && k < 200) begin
      @(negedge clk); k++;
    end
    checkOutput("reachedOffRead", 64'(o_wbm_stb && o_wbm_adr == 32'd18), 64'd1);
    #2 rst = 1'b1;
    #1 checkResetOutputs();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(32'h20, 32'hFFFF_FFFF, cyc);

    for (int t = 0; t < 40; t++) begin
      clearMem();
      maxWait = $urandom_range(0, 3);
      n = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 20);
      mem[1] = 32'(n);
      for (int i = 0; i < 24; i++)
        setDev(i, 32'hA500_0000 | 32'($urandom_range(0, 7)), $urandom, $urandom);
      id = 32'hA500_0000 | 32'($urandom_range(0, 9));
      case ($urandom_range(0, 2))
        0:       mask = 32'hFFFF_FFFF;
        1:       mask = 32'hFFFF_FFFC;
        default: mask = $urandom;
      endcase
      applyStimulus(id, mask, cyc);
    end

    repeat (5) @(negedge clk);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
